// File: rtl/seg_pkg.sv
// Shared segment constants, the hex-to-segment table and the decode helper.
// Latency: none (definitions only).
// Backpressure: none.
package seg_pkg;

  // All segments and the decimal point dark, in active-low form {dp,g,f,e,d,c,b,a}.
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low glyphs 0..F with the decimal point off.
  localparam logic [7:0] HEX_SEG [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // Glyph lookup plus decimal point; act_low=0 returns the active-high pattern.
  function automatic logic [7:0] seg_decode(input logic [3:0] nibble,
                                            input logic       dp,
                                            input logic       act_low);
    logic [7:0] pat;
    pat = HEX_SEG[nibble];
    if (dp) pat[7] = 1'b0;
    return act_low ? pat : ~pat;
  endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Nibble + decimal point to 8-bit segment pattern, with optional glyph blanking.
// Latency: combinational.
// Backpressure: none.
module seg_hex_decoder
  import seg_pkg::*;
#(
  parameter int ACT_LOW = 1
) (
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg
);

  logic [7:0] pat_low;

  // Build the active-low pattern, drop the glyph when blanked (dp kept), then fix polarity.
  always_comb begin
    pat_low = seg_decode(nibble, dp, 1'b1);
    if (blank) pat_low[6:0] = SEG_OFF[6:0];
    seg = (ACT_LOW != 0) ? pat_low : ~pat_low;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner with frame-synchronous update, LZ blanking and guard interval.
// Latency: o_sel/o_seg registered one cycle after div_cnt/cur_digit; new data shown from next frame.
// Backpressure: none; define SEG_SCAN_DIM_EN to add the brightness input and PWM dimming.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS      = 8,
  parameter int SCAN_DIV    = 100000,
  parameter int GUARD       = 2,
  parameter int SEG_ACT_LOW = 1,
  parameter int SEL_ACT_LOW = 1
) (
  input  logic                                         clk_in,
  input  logic                                         reset,
  input  logic                                         en,
`ifdef SEG_SCAN_DIM_EN
  input  logic [3:0]                                   brightness,
`endif
  input  logic                                         load,
  input  logic [4*DIGITS-1:0]                          data_in,
  input  logic [DIGITS-1:0]                            dp_in,
  input  logic                                         blank_lz,
  output logic [7:0]                                   o_seg,
  output logic [DIGITS-1:0]                            o_sel,
  output logic                                         frame_done,
  output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] cur_digit
);

  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0]     DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]     DIG_LAST = CW'(DIGITS - 1);
  localparam logic [7:0]        SEG_DARK = (SEG_ACT_LOW != 0) ? SEG_OFF : ~SEG_OFF;
  localparam logic [DIGITS-1:0] SEL_DARK = (SEL_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [DW-1:0]       div_cnt;
  logic                slot_end, frame_end;
  logic [4*DIGITS-1:0] pend_data, act_data;
  logic [DIGITS-1:0]   pend_dp, act_dp;
  logic [DIGITS-1:0]   lz_mask, sel_hot;
  logic                zero_run;
  logic [3:0]          mux_nib;
  logic                mux_dp, mux_blank;
  logic [7:0]          dec_seg;
  logic                in_guard, pwm_on, lit;

  assign slot_end   = (div_cnt == DIV_LAST);
  assign frame_end  = slot_end && (cur_digit == DIG_LAST);
  assign frame_done = frame_end;

  // Slot divider and digit pointer; the pointer steps once per slot and wraps at the last digit.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      div_cnt   <= '0;
      cur_digit <= '0;
    end else if (slot_end) begin
      div_cnt   <= '0;
      cur_digit <= (cur_digit == DIG_LAST) ? '0 : cur_digit + CW'(1);
    end else begin
      div_cnt   <= div_cnt + DW'(1);
    end
  end

  // Pending captures every load; active only changes at the frame boundary (load there bypasses).
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      pend_data <= '0;
      pend_dp   <= '0;
      act_data  <= '0;
      act_dp    <= '0;
    end else begin
      if (load) begin
        pend_data <= data_in;
        pend_dp   <= dp_in;
      end
      if (frame_end) begin
        act_data <= load ? data_in : pend_data;
        act_dp   <= load ? dp_in   : pend_dp;
      end
    end
  end

  // Digit i is a leading zero when it and every digit above it are zero; digit 0 never is.
  always_comb begin
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run && (act_data[4*i +: 4] == 4'h0);
      lz_mask[i] = zero_run;
    end
  end

  // Select the scanned digit's nibble, dp and blanking, plus its one-hot select.
  always_comb begin
    mux_nib   = '0;
    mux_dp    = 1'b0;
    mux_blank = 1'b0;
    sel_hot   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (cur_digit == CW'(i)) begin
        mux_nib    = act_data[4*i +: 4];
        mux_dp     = act_dp[i];
        mux_blank  = blank_lz && lz_mask[i];
        sel_hot[i] = 1'b1;
      end
    end
  end

  seg_hex_decoder #(.ACT_LOW(SEG_ACT_LOW)) u_dec (
    .nibble (mux_nib),
    .dp     (mux_dp),
    .blank  (mux_blank),
    .seg    (dec_seg)
  );

`ifdef SEG_SCAN_DIM_EN
  logic [3:0] pwm_cnt, bright_q;

  // Free-running PWM phase; brightness only changes at frame boundaries to avoid mid-frame steps.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      pwm_cnt  <= 4'd0;
      bright_q <= 4'd0;
    end else begin
      pwm_cnt <= pwm_cnt + 4'd1;
      if (frame_end) bright_q <= brightness;
    end
  end

  assign pwm_on = (pwm_cnt < bright_q);
`else
  assign pwm_on = 1'b1;
`endif

  assign in_guard = (int'(div_cnt) < GUARD);
  assign lit      = en && !in_guard && pwm_on;

  // Registered drive stage: everything dark in reset, guard, disable or PWM-off phases.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      o_sel <= SEL_DARK;
      o_seg <= SEG_DARK;
    end else if (lit) begin
      o_sel <= (SEL_ACT_LOW != 0) ? ~sel_hot : sel_hot;
      o_seg <= dec_seg;
    end else begin
      o_sel <= SEL_DARK;
      o_seg <= SEG_DARK;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with DIGITS=4, SCAN_DIV=4, GUARD=1, active-low outputs.
// Expected frames are queued when each frame's data is committed and popped as the scan emits them.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_seg_scan_ctrl;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int GUARD    = 1;

  localparam logic [7:0] HEX [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] seg;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic        clk_in   = 1'b0;
  logic        reset    = 1'b0;
  logic        en       = 1'b1;
  logic        load     = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] data_in  = 16'h0;
  logic [3:0]  dp_in    = 4'h0;
  logic [7:0]  o_seg;
  logic [3:0]  o_sel;
  logic        frame_done;
  logic [1:0]  cur_digit;
`ifdef SEG_SCAN_DIM_EN
  logic [3:0]  brightness = 4'd15;
`endif

  // Model of committed (pending) and displayed (active) data.
  logic [15:0] m_pd  = 16'h0;
  logic [15:0] m_ad  = 16'h0;
  logic [3:0]  m_pdp = 4'h0;
  logic [3:0]  m_adp = 4'h0;

  always #5 clk_in = ~clk_in;

  seg_scan_ctrl #(
    .DIGITS      (DIGITS),
    .SCAN_DIV    (SCAN_DIV),
    .GUARD       (GUARD),
    .SEG_ACT_LOW (1),
    .SEL_ACT_LOW (1)
  ) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .en         (en),
`ifdef SEG_SCAN_DIM_EN
    .brightness (brightness),
`endif
    .load       (load),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .o_seg      (o_seg),
    .o_sel      (o_sel),
    .frame_done (frame_done),
    .cur_digit  (cur_digit)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_seg(input logic [15:0] d, input logic [3:0] dp,
                                         input int i, input logic blz);
    logic [7:0]  p;
    logic [3:0]  nib;
    logic [15:0] upper;
    nib   = d[4*i +: 4];
    upper = d >> (4 * i);
    p     = HEX[nib];
    if (blz && i != 0 && upper == 16'h0) p = 8'hFF;
    if (dp[i]) p[7] = 1'b0;
    return p;
  endfunction

  // Queue the guard and lit expectation of every slot of the frame about to be shown.
  task automatic push_frame();
    logic [3:0] s;
    for (int i = 0; i < DIGITS; i++) begin
      exp_q.push_back('{sel: 4'hF, seg: 8'hFF});
      s = 4'h1 << i;
      s = ~s;
      exp_q.push_back('{sel: s, seg: exp_seg(m_ad, m_adp, i, blank_lz)});
    end
  endtask

  task automatic wait_fd();
    int n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (!frame_done && n < 64);
    check("wait_fd", frame_done, 1);
  endtask

  // Entered on the falling edge where frame_done is high; leaves on the next such edge.
  task automatic capture_frame(input bit bnd_load, input logic [15:0] bd, input logic [3:0] bdp,
                               input int mid_at, input logic [15:0] md, input logic [3:0] mdp);
    exp_t e;
    int   fd_extra = 0;
    if (bnd_load) begin
      load = 1'b1; data_in = bd; dp_in = bdp;
      m_pd = bd;   m_pdp = bdp;
    end
    m_ad  = m_pd;
    m_adp = m_pdp;
    push_frame();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_in);
      load = 1'b0;
      if (i < 15 && frame_done) fd_extra++;
      if (i % 4 == 1) begin
        e = exp_q.pop_front();
        check("guard_sel", o_sel, e.sel);
        check("guard_seg", o_seg, e.seg);
      end
      if (i % 4 == 2) begin
        e = exp_q.pop_front();
        check("digit_sel", o_sel, e.sel);
        check("digit_seg", o_seg, e.seg);
        check("cur_digit", cur_digit, i / 4);
      end
      if (i == mid_at) begin
        load = 1'b1; data_in = md; dp_in = mdp;
        m_pd = md;   m_pdp = mdp;
      end
    end
    check("fd_extra", fd_extra, 0);
    check("fd_period", frame_done, 1);
  endtask

  initial begin
    // Reset held for three edges.
    repeat (3) @(negedge clk_in);
    check("rst_sel", o_sel, 4'hF);
    check("rst_seg", o_seg, 8'hFF);
    check("rst_cur", cur_digit, 0);
    check("rst_fd", frame_done, 0);
    reset = 1'b1;

    // Basic display of 12AF with dp on digit 1.
    @(negedge clk_in);
    load = 1'b1; data_in = 16'h12AF; dp_in = 4'b0010;
    m_pd = 16'h12AF; m_pdp = 4'b0010;
    @(negedge clk_in);
    load = 1'b0;
    wait_fd();
    capture_frame(1'b0, 16'h0, 4'h0, -1, 16'h0, 4'h0);

    // Mid-frame load stays invisible until the boundary.
    capture_frame(1'b0, 16'h0, 4'h0, 6, 16'h0000, 4'h0);
    capture_frame(1'b0, 16'h0, 4'h0, -1, 16'h0, 4'h0);

    // Load on the boundary cycle bypasses straight to the display.
    capture_frame(1'b1, 16'h7B3E, 4'b1001, -1, 16'h0, 4'h0);

    // Leading-zero blanking, including a dp on a blanked digit.
    blank_lz = 1'b1;
    capture_frame(1'b1, 16'h0050, 4'b0000, -1, 16'h0, 4'h0);
    capture_frame(1'b1, 16'h0000, 4'b0000, -1, 16'h0, 4'h0);
    capture_frame(1'b1, 16'h0000, 4'b0100, -1, 16'h0, 4'h0);

    // Disable mid-slot: dark one cycle later, frame_done keeps its cadence.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_in);
      if (i == 6) begin
        check("en_lit_sel", o_sel, 4'b1101);
        en = 1'b0;
      end
      if (i == 7) begin
        check("en_off_sel", o_sel, 4'hF);
        check("en_off_seg", o_seg, 8'hFF);
      end
    end
    check("en_fd", frame_done, 1);
    en = 1'b1;

    // Reset mid-frame after a pending load: that load must be discarded.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk_in);
      load = 1'b0;
      if (i == 3) begin
        load = 1'b1; data_in = 16'hBEEF; dp_in = 4'hF;
      end
    end
    reset = 1'b0;
    @(negedge clk_in);
    check("mrst_sel", o_sel, 4'hF);
    check("mrst_seg", o_seg, 8'hFF);
    check("mrst_cur", cur_digit, 0);
    check("mrst_fd", frame_done, 0);
    reset = 1'b1;
    m_pd = 16'h0; m_pdp = 4'h0;
    wait_fd();
    capture_frame(1'b0, 16'h0, 4'h0, -1, 16'h0, 4'h0);

    check("sb_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Parametrised multiplexed seven-segment display controller; successor to the fixed 8-digit hex display driver used at the SoC top level.
- Sits beside the CPU/clock-divider in the top wrapper and displays a debug register word, e.g. the CPU output register.
- Adds:
  - generic digit count, scan rate and output polarity;
  - tear-free frame-synchronous data update;
  - per-digit decimal points;
  - leading-zero blanking;
  - an anti-ghosting guard interval.

Parameters:
- DIGITS, 8: number of digits; 1..16.
- SCAN_DIV, 100000: clk_in cycles per digit slot; ≥ GUARD+2.
- GUARD, 2: cycles at the start of each slot during which all digits are off.
- SEG_ACT_LOW, 1: 1 means o_seg is active-low.
- SEL_ACT_LOW, 1: 1 means o_sel is active-low.

Ports:
- clk_in, input, 1: system clock.
- reset, input, 1: synchronous, active-low reset.
- en, input, 1: display enable.
- load, input, 1: single-cycle strobe that captures data_in and dp_in.
- data_in, input, 4*DIGITS: nibble i is shown on digit i; digit 0 is the rightmost.
- dp_in, input, DIGITS: decimal point for digit i; 1 = lit.
- blank_lz, input, 1: leading-zero blanking enable.
- o_seg, output, 8: segments {dp,g,f,e,d,c,b,a}.
- o_sel, output, DIGITS: one-hot digit select.
- frame_done, output, 1: one-cycle pulse when a full scan frame completes.
- cur_digit, output, $clog2(DIGITS) (min 1): index of the digit currently scanned.

Behaviour:
- Reset (reset=0 sampled on a clk_in edge):
  - div_cnt=0, cur_digit=0.
  - Pending and active data/dp registers = 0.
  - o_seg = all segments off (8'hFF when SEG_ACT_LOW).
  - o_sel = all digits off.
  - frame_done=0.
  - Reset asserted mid-frame discards pending data. The scan restarts at digit 0 on the first cycle after reset is released.
- Divider:
  - div_cnt counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1 it wraps to 0 and cur_digit advances, wrapping from DIGITS-1 to 0.
- Frame boundary (wrap of cur_digit from DIGITS-1 to 0):
  - active <= pending.
  - frame_done=1 for exactly that cycle.
- Load:
  - load=1 writes pending <= {data_in, dp_in}.
  - load coinciding with a frame boundary: active <= data_in/dp_in directly (bypass); pending is also updated.
  - Multiple loads in one frame: the last one wins.
- Output stage: registered, one cycle latency from div_cnt/cur_digit.
  - When div_cnt < GUARD: o_sel and o_seg are all off.
  - Otherwise: o_sel asserts only bit cur_digit, and o_seg = decode(active nibble) with dp from the active dp bit.
- Hex decode, active-low values with dp off: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
  - A lit dp clears bit 7.
  - When SEG_ACT_LOW=0, the output is the bitwise inverse.
- Leading-zero blanking (blank_lz=1):
  - Digit i is blanked (segments off, dp still honoured) if its nibble and every higher nibble are 0.
  - Digit 0 is never blanked.
- en=0:
  - Outputs are forced off on the next cycle.
  - Counters and load/pending/active updates continue, so re-enabling is glitch-free.
  - frame_done still pulses.
- DIGITS=1: cur_digit stays at 0, and every slot wrap is a frame boundary.

Optional Feature:
- Macro: SEG_SCAN_DIM_EN.
- When defined:
  - Adds input brightness [3:0] and a 4-bit PWM counter that runs 0..15, incrementing every clk_in.
  - Outside the guard interval, o_sel/o_seg are lit only while pwm_cnt < brightness.
  - brightness=0 means always dark; brightness=15 means lit 15 of every 16 cycles.
  - brightness is sampled at the frame boundary only.
- When not defined: no port, no counter; lit for the whole non-guard slot.

Decomposition:
- Package seg_pkg holds:
  - the SEG_OFF constant;
  - the 16-entry hex-to-segment constant table;
  - the function seg_decode(nibble, dp, act_low).
- One natural sub-module: seg_hex_decoder (combinational nibble+dp to 8-bit pattern), instantiated once on the muxed nibble.

Test Plan (DIGITS=4, SCAN_DIV=4, GUARD=1, active-low):
1. Reset held 3 cycles, then released, load data_in=16'h12AF, dp_in=4'b0010:
   - After the next frame_done: digit 0 shows 8E, digit 1 shows 08 (A with dp), digit 2 A4, digit 3 F9.
   - o_sel cycles 1110, 1101, 1011, 0111.
2. Guard and timing:
   - In every slot, the first output cycle has o_sel=1111 and o_seg=FF.
   - frame_done pulses exactly every 16 cycles.
3. Tear-free update and bypass:
   - load 16'h0000 mid-frame: the displayed digits do not change until frame_done.
   - load asserted on the frame-boundary cycle: the new value is displayed from digit 0 of the next frame.
4. Leading-zero blanking: blank_lz=1, data 16'h0050:
   - Digits 3 and 2 are FF.
   - Digit 1 shows 92; digit 0 shows C0.
   - Data 16'h0000: only digit 0 shows C0.
5. Enable and mid-operation reset:
   - en=0 mid-slot: outputs are off one cycle later; frame_done keeps pulsing.
   - reset=0 mid-frame: next-cycle outputs are off, cur_digit=0, and the display is blank (all-zero data) after release.
6. SEG_SCAN_DIM_EN with brightness=4:
   - Per 16-cycle PWM window, the lit cycles equal 4 minus any overlap with guard cycles.
   - brightness=0: no digit is ever selected.
